// File: rtl/fifo_status_pkg.sv
// Shared types for the status FIFO.
// Encodes the per-cycle operation applied to the occupancy state.
package fifo_status_pkg;

    typedef enum logic [2:0] {
        OP_IDLE,
        OP_PUSH,
        OP_POP,
        OP_BOTH,
        OP_FLUSH
    } fifo_op_e;

endpackage

// File: rtl/fifo_status_ram.sv
// Single write port, asynchronous read port storage array.
// Contents are never reset.
module ram_1w1r_async #(
    parameter int width_p = 8,
    parameter int els_p   = 4,
    localparam int aw_lp  = (els_p > 1) ? $clog2(els_p) : 1
) (
    input  logic               w_clk_i,
    input  logic               w_v_i,
    input  logic [aw_lp-1:0]   w_addr_i,
    input  logic [width_p-1:0] w_data_i,
    input  logic [aw_lp-1:0]   r_addr_i,
    output logic [width_p-1:0] r_data_o
);

    logic [width_p-1:0] mem [els_p];

    always_ff @(posedge w_clk_i) begin
        if (w_v_i) begin
            mem[w_addr_i] <= w_data_i;
        end
    end

    assign r_data_o = mem[r_addr_i];

endmodule

// File: rtl/fifo_status.sv
// Synchronous FIFO with occupancy count, threshold flags and a
// sticky underflow flag. Full/empty are derived from the count only.
module fifo_status
    import fifo_status_pkg::*;
#(
    parameter int width_p  = 8,
    parameter int depth_p  = 128,
    parameter int afull_p  = depth_p - 2,
    parameter int aempty_p = 2,
    localparam int cw_lp   = $clog2(depth_p + 1),
    localparam int pw_lp   = $clog2(depth_p)
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               valid_i,
    input  logic [width_p-1:0] data_i,
    output logic               ready_o,
    input  logic               yumi_i,
    output logic               valid_o,
    output logic [width_p-1:0] data_o,
    input  logic               flush_i,
    output logic [cw_lp-1:0]   count_o,
    output logic               almost_full_o,
    output logic               almost_empty_o,
    output logic               err_o
);

    if (depth_p < 2) begin : g_bad_depth
        $error("fifo_status: depth_p must be >= 2");
    end
    if (afull_p < 1 || afull_p > depth_p) begin : g_bad_afull
        $error("fifo_status: afull_p must be in 1..depth_p");
    end
    if (aempty_p < 0 || aempty_p > depth_p - 1) begin : g_bad_aempty
        $error("fifo_status: aempty_p must be in 0..depth_p-1");
    end

    localparam logic [pw_lp-1:0] last_ptr_lp = pw_lp'(depth_p - 1);
    localparam logic [cw_lp-1:0] full_cnt_lp = cw_lp'(depth_p);
    localparam logic [cw_lp-1:0] afull_lp    = cw_lp'(afull_p);
    localparam logic [cw_lp-1:0] aempty_lp   = cw_lp'(aempty_p);

    logic [pw_lp-1:0] wr_ptr;
    logic [pw_lp-1:0] rd_ptr;
    logic [cw_lp-1:0] count;
    logic             err;

    logic             push;
    logic             pop;
    logic             under;
    fifo_op_e         op;

    logic [pw_lp-1:0] wr_ptr_inc;
    logic [pw_lp-1:0] rd_ptr_inc;

    assign ready_o = (count != full_cnt_lp);
    assign valid_o = (count != '0);

    // Flush wins over same-cycle traffic, so it masks push and pop.
    assign push  = valid_i & ready_o & ~flush_i;
    assign pop   = yumi_i & valid_o & ~flush_i;
    assign under = yumi_i & ~valid_o & ~flush_i;

    assign wr_ptr_inc = (wr_ptr == last_ptr_lp) ? '0 : wr_ptr + 1'b1;
    assign rd_ptr_inc = (rd_ptr == last_ptr_lp) ? '0 : rd_ptr + 1'b1;

    always_comb begin
        op = OP_IDLE;
        unique case (1'b1)
            flush_i:       op = OP_FLUSH;
            push && pop:   op = OP_BOTH;
            push && !pop:  op = OP_PUSH;
            pop && !push:  op = OP_POP;
            default:       op = OP_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            unique case (op)
                OP_FLUSH: begin
                    wr_ptr <= '0;
                    rd_ptr <= '0;
                    count  <= '0;
                end
                OP_BOTH: begin
                    wr_ptr <= wr_ptr_inc;
                    rd_ptr <= rd_ptr_inc;
                end
                OP_PUSH: begin
                    wr_ptr <= wr_ptr_inc;
                    count  <= count + 1'b1;
                end
                OP_POP: begin
                    rd_ptr <= rd_ptr_inc;
                    count  <= count - 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            err <= 1'b0;
        end else if (flush_i) begin
            err <= 1'b0;
        end else if (under) begin
            err <= 1'b1;
        end
    end

    ram_1w1r_async #(
        .width_p (width_p),
        .els_p   (depth_p)
    ) u_ram (
        .w_clk_i  (clk_i),
        .w_v_i    (push & reset_n_i),
        .w_addr_i (wr_ptr),
        .w_data_i (data_i),
        .r_addr_i (rd_ptr),
        .r_data_o (data_o)
    );

    assign count_o        = count;
    assign err_o          = err;
    assign almost_full_o  = (count >= afull_lp);
    assign almost_empty_o = (count <= aempty_lp);

endmodule

// File: tb/tb_fifo_status.sv
// Directed bench for fifo_status at width 8, depth 5, afull 4, aempty 1.
module tb_fifo_status;

    logic       clk_i;
    logic       reset_n_i;
    logic       valid_i;
    logic [7:0] data_i;
    logic       ready_o;
    logic       yumi_i;
    logic       valid_o;
    logic [7:0] data_o;
    logic       flush_i;
    logic [2:0] count_o;
    logic       almost_full_o;
    logic       almost_empty_o;
    logic       err_o;

    int n_cmp = 0;
    int n_bad = 0;

    fifo_status #(
        .width_p  (8),
        .depth_p  (5),
        .afull_p  (4),
        .aempty_p (1)
    ) dut (
        .clk_i          (clk_i),
        .reset_n_i      (reset_n_i),
        .valid_i        (valid_i),
        .data_i         (data_i),
        .ready_o        (ready_o),
        .yumi_i         (yumi_i),
        .valid_o        (valid_o),
        .data_o         (data_o),
        .flush_i        (flush_i),
        .count_o        (count_o),
        .almost_full_o  (almost_full_o),
        .almost_empty_o (almost_empty_o),
        .err_o          (err_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic flags(input string tag, input logic [2:0] cnt,
                         input logic rdy, input logic vld,
                         input logic af, input logic ae, input logic er);
        check({tag, ".count"}, 32'(count_o), 32'(cnt));
        check({tag, ".ready"}, 32'(ready_o), 32'(rdy));
        check({tag, ".valid"}, 32'(valid_o), 32'(vld));
        check({tag, ".afull"}, 32'(almost_full_o), 32'(af));
        check({tag, ".aempty"}, 32'(almost_empty_o), 32'(ae));
        check({tag, ".err"}, 32'(err_o), 32'(er));
    endtask

    task automatic step(input logic v, input logic [7:0] d,
                        input logic y, input logic f);
        valid_i = v;
        data_i  = d;
        yumi_i  = y;
        flush_i = f;
        @(posedge clk_i);
        #1;
        valid_i = 1'b0;
        yumi_i  = 1'b0;
        flush_i = 1'b0;
    endtask

    logic [7:0] exp_q[$];
    logic [7:0] d;

    initial begin
        reset_n_i = 1'b0;
        valid_i   = 1'b0;
        data_i    = '0;
        yumi_i    = 1'b0;
        flush_i   = 1'b0;
        #2;
        flags("rst", 3'd0, 1, 0, 0, 1, 0);
        @(negedge clk_i);
        reset_n_i = 1'b1;
        #1;

        // Fill to capacity.
        for (int i = 0; i < 5; i++) begin
            step(1, 8'h11 + 8'(i), 0, 0);
            check("fill.count", 32'(count_o), 32'(i + 1));
            check("fill.head", 32'(data_o), 32'h11);
            check("fill.afull", 32'(almost_full_o), 32'(i + 1 >= 4));
            check("fill.aempty", 32'(almost_empty_o), 32'(i + 1 <= 1));
        end
        flags("full", 3'd5, 0, 1, 1, 0, 0);

        // Push blocked at full even with a same-cycle pop.
        step(1, 8'h66, 1, 0);
        flags("fullpop", 3'd4, 1, 1, 1, 0, 0);
        check("fullpop.head", 32'(data_o), 32'h12);
        step(1, 8'h66, 0, 0);
        check("refill.count", 32'(count_o), 32'd5);

        // Drain to two entries, checking order.
        for (int i = 0; i < 3; i++) begin
            check("drain.data", 32'(data_o), 32'h12 + 32'(i));
            step(0, 8'h00, 1, 0);
        end
        check("drain.count", 32'(count_o), 32'd2);
        exp_q.push_back(8'h15);
        exp_q.push_back(8'h66);

        // Steady push+pop at count 2; pointers wrap repeatedly.
        for (int i = 0; i < 12; i++) begin
            d = exp_q.pop_front();
            check("pp.data", 32'(data_o), 32'(d));
            exp_q.push_back(8'h80 + 8'(i));
            step(1, 8'h80 + 8'(i), 1, 0);
            check("pp.count", 32'(count_o), 32'd2);
        end
        check("pp.tail0", 32'(data_o), 32'h8a);
        step(0, 8'h00, 1, 0);
        check("pp.tail1", 32'(data_o), 32'h8b);
        step(0, 8'h00, 1, 0);
        flags("empty", 3'd0, 1, 0, 0, 1, 0);

        // Underflow while pushing into an empty FIFO.
        step(1, 8'ha5, 1, 0);
        flags("under", 3'd1, 1, 1, 0, 1, 1);
        check("under.data", 32'(data_o), 32'ha5);

        // Flush overrides same-cycle traffic and clears err.
        step(1, 8'hb1, 0, 0);
        step(1, 8'hb2, 0, 0);
        check("preflush.count", 32'(count_o), 32'd3);
        step(1, 8'hb3, 1, 1);
        flags("flush", 3'd0, 1, 0, 0, 1, 0);

        // Asynchronous reset mid-cycle at count 3.
        step(1, 8'hc1, 0, 0);
        step(1, 8'hc2, 0, 0);
        step(1, 8'hc3, 0, 0);
        check("prerst.count", 32'(count_o), 32'd3);
        #3;
        reset_n_i = 1'b0;
        #1;
        flags("arst", 3'd0, 1, 0, 0, 1, 0);
        step(1, 8'hc4, 1, 0);
        flags("arst.edge", 3'd0, 1, 0, 0, 1, 0);
        #3;
        reset_n_i = 1'b1;
        step(1, 8'hd7, 0, 0);
        flags("post", 3'd1, 1, 1, 0, 1, 0);
        check("post.data", 32'(data_o), 32'hd7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
